fifo_sync_wconv: RTL
====================

Name: fifo_sync_wconv

Overview:
Single-clock FIFO with integer-ratio data-width conversion in either direction (narrow-to-wide or wide-to-narrow). It also provides a selectable first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty thresholds, a synchronous flush, and one-cycle overflow and underflow error pulses. It is the single-clock successor to the team's async width-converting FIFO, used wherever producer and consumer share a clock.

Parameters:
DWI, 8, write data width in bits
AWI, 7, write-side depth is 2^AWI words of DWI
DWO, 16, read data width in bits
AWO, 6, read-side depth is 2^AWO words of DWO
FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through
AF_LVL, 4, almost_full asserts when free DWI slots <= AF_LVL
AE_LVL, 2, almost_empty asserts when rd_data_cnt <= AE_LVL

Legality constraints (checked by elaboration assertion):
- DWI*2^AWI == DWO*2^AWO.
- max(DWI,DWO)/min(DWI,DWO) is a power of 2 and at most 8.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all contents
wr_en  in  1  write request
wr_data  in  DWI  write data
rd_en  in  1  read request
rd_data  out  DWO  read data
full  out  1  no room for one DWI word
almost_full  out  1  free DWI slots <= AF_LVL
empty  out  1  no complete DWO word readable (FWFT: rd_data not valid)
almost_empty  out  1  rd_data_cnt <= AE_LVL
wr_data_cnt  out  AWI+1  occupancy in DWI units
rd_data_cnt  out  AWO+1  complete DWO words stored
wr_err  out  1  one-cycle pulse: write rejected because full
rd_err  out  1  one-cycle pulse: read rejected because empty

Behaviour:
Reset:
- Asynchronous, active-low.
- All pointers and counts go to 0; empty=1, almost_empty=1, full=0, almost_full=0.
- rd_data=0; wr_err=0, rd_err=0.

Flush:
- When flush=1 at a clock edge: same state as reset, and any partially assembled word is discarded.
- wr_en and rd_en are ignored in that cycle.

Storage and ordering:
- Storage is 2^AWI*DWI bits, organised in G = min(DWI,DWO) bit units.
- Narrow-to-wide: the first-written DWI word occupies the LSBs of the DWO word.
- Wide-to-narrow: the LSB slice of a DWI word is read first.

Acceptance rules:
- A write is accepted when wr_en && !full. A read is accepted when rd_en && !empty.
- All flags sampled are the registered values from before the edge. Therefore:
  - At full, a simultaneous rd_en+wr_en accepts only the read.
  - At empty, a simultaneous rd_en+wr_en accepts only the write.
- Rejected write: data is dropped, state unchanged, wr_err=1 for exactly the next cycle.
- Rejected read: rd_data holds its value, state unchanged, rd_err=1 for exactly the next cycle.

Counts (all flags and counts registered, updated on the edge after an accepted operation):
- wr_data_cnt = 2^AWI - floor(free_bits/DWI).
- rd_data_cnt = floor(stored_bits/DWO). Partial output words are not counted and not readable.
- full = (wr_data_cnt == 2^AWI).
- empty = (rd_data_cnt == 0), standard mode.

Standard mode (FWFT=0):
- rd_data updates on the edge that accepts the read (1-cycle latency) and holds until the next accepted read.
- A write completing a DWO word at edge N clears empty at edge N.

FWFT mode (FWFT=1):
- The head word is pre-fetched into an output register.
- empty deasserts and rd_data becomes valid at edge N+1 for a first word completed at edge N.
- An accepted read pops the head; the next word appears on the same edge if available, otherwise empty=1.
- rd_data_cnt includes the pre-fetched word.

Pointers:
- Pointers wrap modulo the storage size.
- Sustained simultaneous reads and writes with a non-full, non-empty FIFO run at full throughput, with no bubbles in either mode.

Test Plan:
1. Defaults, FWFT=0: write 0x01,0x02; then rd_en=1 -> rd_data_cnt=1 after the second write; next cycle rd_data=0x0201, then empty=1, wr_data_cnt=0.
2. Defaults: 128 consecutive writes -> full=1 with wr_data_cnt=128, rd_data_cnt=64, almost_full from the 124th write; 129th write -> wr_err pulses for 1 cycle and contents are unchanged.
3. rd_en on empty after reset -> rd_err pulses for 1 cycle, rd_data stays 0; simultaneous rd_en+wr_en at full -> only the read is accepted, wr_err=1.
4. DWI=16, DWO=8, AWI=6, AWO=7, FWFT=1: write 0xA1B2 at edge N -> empty=0 and rd_data=0xB2 at N+1; pop -> rd_data=0xA1; pop -> empty=1.
5. Defaults: write 3 bytes -> wr_data_cnt=3, rd_data_cnt=1; read one word -> empty=1 while wr_data_cnt=1; a 4th write completes the word -> rd_data_cnt=1.
6. Half-full FIFO, then flush=1 together with wr_en=1 -> next cycle all counts are 0, empty=1, no write is stored; an async rst_n pulse mid-stream gives the same result immediately.

Source files
------------

// File: rtl/fifo_sync_wconv.sv
// fifo_sync_wconv: single-clock FIFO with integer-ratio width conversion.
//
// Storage is a ring of G-bit units, with G = min(DWI,DWO). A write deposits
// DWI/G units and a read removes DWO/G units. Unit 0 of a word always sits in
// the LSBs, so narrow-to-wide packs the first write low and wide-to-narrow
// emits the low slice first.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   flush             synchronous clear; wr_en/rd_en ignored that cycle
//   wr_en, wr_data    write request, DWI-bit data
//   rd_en, rd_data    read request, DWO-bit registered data
//   full, almost_full registered write-side flags
//   empty, almost_empty registered read-side flags (FWFT: empty = !rd_data valid)
//   wr_data_cnt       occupancy in DWI units
//   rd_data_cnt       complete DWO words held (FWFT: includes output register)
//   wr_err, rd_err    one-cycle pulses for rejected write / read
module fifo_sync_wconv #(
    parameter int DWI    = 8,
    parameter int AWI    = 7,
    parameter int DWO    = 16,
    parameter int AWO    = 6,
    parameter int FWFT   = 0,
    parameter int AF_LVL = 4,
    parameter int AE_LVL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [DWI-1:0]   wr_data,
    input  logic             rd_en,
    output logic [DWO-1:0]   rd_data,
    output logic             full,
    output logic             almost_full,
    output logic             empty,
    output logic             almost_empty,
    output logic [AWI:0]     wr_data_cnt,
    output logic [AWO:0]     rd_data_cnt,
    output logic             wr_err,
    output logic             rd_err
);
    localparam int G     = (DWI < DWO) ? DWI : DWO;
    localparam int WU    = DWI / G;          // units per write
    localparam int RU    = DWO / G;          // units per read
    localparam int NU    = (1 << AWI) * WU;  // total units of storage
    localparam int UW    = $clog2(NU);
    localparam int CW    = UW + 1;
    localparam int WCW   = AWI + 1;
    localparam int RCW   = AWO + 1;
    localparam int RATIO = (DWI > DWO) ? DWI / DWO : DWO / DWI;
    localparam int WMAX  = (DWI > DWO) ? DWI : DWO;

    generate
        if (DWI * (1 << AWI) != DWO * (1 << AWO)) begin : g_bad_size
            $error("fifo_sync_wconv: DWI*2^AWI must equal DWO*2^AWO");
        end
        if ((WMAX % G) != 0 || (RATIO & (RATIO - 1)) != 0 || RATIO > 8) begin : g_bad_ratio
            $error("fifo_sync_wconv: width ratio must be a power of 2, at most 8");
        end
    endgenerate

    logic [G-1:0]   mem_q [NU];
    logic [UW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d, mem_cnt, free_d;
    logic           ovld_q, ovld_d;
    logic [DWO-1:0] rd_data_q, rd_data_d, rd_word;
    logic [WCW-1:0] wdc_q, wdc_d;
    logic [RCW-1:0] rdc_q, rdc_d;
    logic           full_q, full_d, af_q, af_d, empty_q, empty_d, ae_q, ae_d;
    logic           wr_err_q, wr_err_d, rd_err_q, rd_err_d;
    logic           wr_acc, rd_acc, mem_rd;

    always_comb begin
        wr_acc  = wr_en && !full_q && !flush;
        rd_acc  = rd_en && !empty_q && !flush;
        // cnt_q is the total held; in FWFT the output register owns RU of it.
        mem_cnt = cnt_q - (ovld_q ? CW'(RU) : CW'(0));
        if (FWFT != 0)
            // Prefetch when the output register is free or being popped.
            mem_rd = (!ovld_q || rd_acc) && (mem_cnt >= CW'(RU)) && !flush;
        else
            mem_rd = rd_acc;

        rd_word = '0;
        for (int i = 0; i < RU; i++)
            rd_word[i*G +: G] = mem_q[rptr_q + UW'(i)];

        cnt_d = cnt_q;
        if (wr_acc) cnt_d = cnt_d + CW'(WU);
        if (rd_acc) cnt_d = cnt_d - CW'(RU);
        wptr_d    = wr_acc ? wptr_q + UW'(WU) : wptr_q;
        rptr_d    = mem_rd ? rptr_q + UW'(RU) : rptr_q;
        rd_data_d = mem_rd ? rd_word : rd_data_q;

        ovld_d = 1'b0;
        if (FWFT != 0) begin
            if (mem_rd)      ovld_d = 1'b1;
            else if (rd_acc) ovld_d = 1'b0;
            else             ovld_d = ovld_q;
        end

        wr_err_d = wr_en && full_q && !flush;
        rd_err_d = rd_en && empty_q && !flush;

        if (flush) begin
            cnt_d     = '0;
            wptr_d    = '0;
            rptr_d    = '0;
            ovld_d    = 1'b0;
            rd_data_d = '0;
        end

        // Flags are derived from the next-state count so they are registered
        // and valid on the same edge that commits the operation.
        free_d  = CW'(NU) - cnt_d;
        wdc_d   = WCW'(CW'(1 << AWI) - free_d / CW'(WU));
        rdc_d   = RCW'(cnt_d / CW'(RU));
        full_d  = (wdc_d == WCW'(1 << AWI));
        af_d    = int'(free_d / CW'(WU)) <= AF_LVL;
        empty_d = (FWFT != 0) ? !ovld_d : (rdc_d == '0);
        ae_d    = int'(rdc_d) <= AE_LVL;
    end

    // Data storage carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc)
            for (int i = 0; i < WU; i++)
                mem_q[wptr_q + UW'(i)] <= wr_data[i*G +: G];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovld_q    <= 1'b0;
            rd_data_q <= '0;
            wdc_q     <= '0;
            rdc_q     <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            empty_q   <= 1'b1;
            ae_q      <= 1'b1;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            ovld_q    <= ovld_d;
            rd_data_q <= rd_data_d;
            wdc_q     <= wdc_d;
            rdc_q     <= rdc_d;
            full_q    <= full_d;
            af_q      <= af_d;
            empty_q   <= empty_d;
            ae_q      <= ae_d;
            wr_err_q  <= wr_err_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign rd_data      = rd_data_q;
    assign full         = full_q;
    assign almost_full  = af_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;
    assign wr_data_cnt  = wdc_q;
    assign rd_data_cnt  = rdc_q;
    assign wr_err       = wr_err_q;
    assign rd_err       = rd_err_q;
endmodule
